// File: rtl/kanade_muldiv_pkg.sv
// Shared definitions for the kanade32 multiply/divide unit.
// The decode stage imports the op encodings from here as well.
package kanade_muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on launch, and sign
// restoration of the raw unsigned product or {remainder, quotient}.
module muldiv_signfix
    import kanade_muldiv_pkg::*;
(
    input  logic        signed_op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic [31:0] a_mag_o,
    output logic [31:0] b_mag_o,
    output logic        a_neg_o,
    output logic        b_neg_o,
    input  logic        is_div_i,
    input  logic        neg_res_i,
    input  logic        neg_rem_i,
    input  logic [63:0] raw_i,
    output logic [63:0] fixed_o
);

    always_comb begin
        a_neg_o = signed_op_i & src_a_i[31];
        b_neg_o = signed_op_i & src_b_i[31];
        a_mag_o = a_neg_o ? (~src_a_i + 32'd1) : src_a_i;
        b_mag_o = b_neg_o ? (~src_b_i + 32'd1) : src_b_i;

        // Divide: hi is the remainder (dividend sign), lo the quotient.
        if (is_div_i) begin
            fixed_o[63:32] = neg_rem_i ? (~raw_i[63:32] + 32'd1) : raw_i[63:32];
            fixed_o[31:0]  = neg_res_i ? (~raw_i[31:0] + 32'd1) : raw_i[31:0];
        end else begin
            fixed_o = neg_res_i ? (~raw_i + 64'd1) : raw_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the kanade32 EX stage.
// Handshake: start is taken only in IDLE; busy is high in every other state; done pulses once per finished op.
module muldiv_unit
    import kanade_muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result_x64,
    output logic        div_by_zero
);

    localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

    muldiv_state_e state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic          div_q, div_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          neg_res_q, neg_res_d;
    logic          neg_rem_q, neg_rem_d;
    logic [63:0]   acc_q, acc_d;
    logic [63:0]   result_q, result_d;
    logic          dbz_q, dbz_d;

    logic        op_is_div;
    logic        op_is_signed;
    logic [31:0] a_mag, b_mag;
    logic        a_neg, b_neg;
    logic [63:0] fixed;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;

    assign op_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_is_signed = (op == OP_MULT) || (op == OP_DIV);

    muldiv_signfix u_signfix (
        .signed_op_i (op_is_signed),
        .src_a_i     (src_a),
        .src_b_i     (src_b),
        .a_mag_o     (a_mag),
        .b_mag_o     (b_mag),
        .a_neg_o     (a_neg),
        .b_neg_o     (b_neg),
        .is_div_i    (div_q),
        .neg_res_i   (neg_res_q),
        .neg_rem_i   (neg_rem_q),
        .raw_i       (acc_q),
        .fixed_o     (fixed)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_d     = div_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        result_d  = result_q;
        dbz_d     = dbz_q;

        // acc holds {partial, multiplier} for multiply, {remainder, dividend/quotient} for divide.
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        div_trial = acc_q[63:31] - {1'b0, b_q};

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    div_d     = op_is_div;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    count_d   = 5'd0;
                    if (op_is_div && (src_b == 32'd0)) begin
                        result_d = {src_a, 32'hFFFF_FFFF};
                        dbz_d    = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d   = op_is_div ? {32'd0, a_mag} : {32'd0, b_mag};
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (div_q) begin
                        if (!div_trial[32]) begin
                            acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[62:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    if (count_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = fixed;
                    dbz_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 5'd0;
            div_q     <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= 64'd0;
            result_q  <= 64'd0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign result_x64  = result_q;
    assign div_by_zero = dbz_q;

endmodule
